// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod serial link (transmitter and receiver).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gamepad_pmod_pkg;

    // Default frame length: one controller.
    localparam int NUM_BITS_DEFAULT = 12;

    // Button bit positions inside the frame vector; bit 11 goes out first.
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    // Transmitter frame sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        BIT_LO = 2'd2,
        BIT_HI = 2'd3
    } state_e;

endpackage

// File: rtl/gamepad_pmod_tx.sv
// Serialises a snapshot of the button vector as latch pulse + NUM_BITS clocked bits, MSB first.
// Latency: pmod_latch rises 1 cycle after start; done pulses 1 + LATCH + NUM_BITS*2*HALF cycles after start.
// Backpressure: start is only accepted while busy=0; a start during a frame is dropped.
module gamepad_pmod_tx
    import gamepad_pmod_pkg::*;
#(
    parameter int NUM_BITS     = NUM_BITS_DEFAULT,
    parameter int LATCH_CYCLES = 4,
    parameter int HALF_PERIOD  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] buttons,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pmod_latch,
    output logic                pmod_clk,
    output logic                pmod_data
);

    localparam int PH_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BC_W   = $clog2(NUM_BITS + 1);

    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(NUM_BITS - 1);

    state_e              state_q,   state_d;
    logic [PH_W-1:0]     phase_q,   phase_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS-1:0] shreg_q,   shreg_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                latch_q,   latch_d;
    logic                pclk_q,    pclk_d;
    logic                data_q,    data_d;

    // Next-state logic; pin outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + PH_W'(1);
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (start) begin
                    shreg_d   = buttons;
                    bit_cnt_d = '0;
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    phase_d = '0;
                    state_d = BIT_LO;
                end
            end
            BIT_LO: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    state_d = BIT_HI;
                end
            end
            BIT_HI: begin
                if (phase_q == HALF_LAST) begin
                    phase_d   = '0;
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BIT_LO;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        latch_d = (state_d == LATCH);
        pclk_d  = (state_d == BIT_HI);
        // Data only moves when a low half-period begins, so it is stable across the rising edge.
        case (state_d)
            BIT_LO:  data_d = shreg_d[NUM_BITS-1];
            BIT_HI:  data_d = data_q;
            default: data_d = 1'b0;
        endcase
    end

    // State, counters, shift register and output flops; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            latch_q   <= latch_d;
            pclk_q    <= pclk_d;
            data_q    <= data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pmod_latch = latch_q;
    assign pmod_clk   = pclk_q;
    assign pmod_data  = data_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
module tb_gamepad_pmod_tx;
    import gamepad_pmod_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, start1;
    logic [11:0] btn0, btn1;
    logic        busy0, done0, latch0, pclk0, data0;
    logic        busy1, done1, latch1, pclk1, data1;

    gamepad_pmod_tx #(.NUM_BITS(12), .LATCH_CYCLES(4), .HALF_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .buttons(btn0), .start(start0),
        .busy(busy0), .done(done0), .pmod_latch(latch0), .pmod_clk(pclk0), .pmod_data(data0)
    );

    gamepad_pmod_tx #(.NUM_BITS(12), .LATCH_CYCLES(1), .HALF_PERIOD(1)) dut_f (
        .clk(clk), .reset(reset), .buttons(btn1), .start(start1),
        .busy(busy1), .done(done1), .pmod_latch(latch1), .pmod_clk(pclk1), .pmod_data(data1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, req);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int half_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Reference model: frame position k (cycles since the accepting edge) -> pin values.
    // Vector layout {busy, done, latch, clk, data}.
    logic [4:0]  exp_v [2];
    bit          act   [2];
    int          kk    [2];
    logic [11:0] cap   [2];
    logic        m_st;
    logic [11:0] m_b;
    int          m_l, m_h, m_j, m_len;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_st  = (d == 0) ? start0 : start1;
            m_b   = (d == 0) ? btn0 : btn1;
            m_l   = lat_of(d);
            m_h   = half_of(d);
            m_len = m_l + 12 * 2 * m_h;
            if (reset) begin
                act[d]   = 1'b0;
                kk[d]    = 0;
                exp_v[d] = '0;
            end else begin
                if (m_st && !exp_v[d][4]) begin
                    act[d] = 1'b1;
                    kk[d]  = 1;
                    cap[d] = m_b;
                end else if (act[d]) begin
                    kk[d]++;
                end
                exp_v[d] = '0;
                if (act[d]) begin
                    if (kk[d] <= m_len) begin
                        exp_v[d][4] = 1'b1;
                        if (kk[d] <= m_l) begin
                            exp_v[d][2] = 1'b1;
                        end else begin
                            m_j = kk[d] - m_l - 1;
                            exp_v[d][1] = ((m_j % (2 * m_h)) >= m_h);
                            exp_v[d][0] = cap[d][11 - m_j / (2 * m_h)];
                        end
                    end else begin
                        exp_v[d][3] = 1'b1;
                        act[d] = 1'b0;
                    end
                end
            end
        end
        #1;
        check("model_dut", int'({busy0, done0, latch0, pclk0, data0}), int'(exp_v[0]));
        check("model_dut_f", int'({busy1, done1, latch1, pclk1, data1}), int'(exp_v[1]));
    end

    // Loopback receiver: clear on latch, shift pmod_data in on each pmod_clk rising edge.
    logic [11:0] rx0 = '0, rx1 = '0;
    logic        pc0_prev = 1'b0, pc1_prev = 1'b0;
    always @(negedge clk) begin
        if (latch0) rx0 = '0;
        else if (pclk0 && !pc0_prev) rx0 = {rx0[10:0], data0};
        pc0_prev = pclk0;
        if (latch1) rx1 = '0;
        else if (pclk1 && !pc1_prev) rx1 = {rx1[10:0], data1};
        pc1_prev = pclk1;
    end

    int lat_first, lat_last, lat_n, rises, done_n, done_c, dhi_first, dhi_last, busy_last;

    // Pulse start in the current cycle (cycle 0) and tally cycles 1..ncyc.
    task automatic pulse_and_tally(input int d, input logic [11:0] b, input int ncyc,
                                   input int chg_c, input logic [11:0] chg_b);
        logic       pc_prev;
        logic [4:0] o;
        if (d == 0) begin start0 = 1'b1; btn0 = b; end
        else        begin start1 = 1'b1; btn1 = b; end
        lat_first = -1; lat_last = -1; lat_n = 0; rises = 0; done_n = 0; done_c = -1;
        dhi_first = -1; dhi_last = -1; busy_last = -1;
        pc_prev = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (c == chg_c) begin
                if (d == 0) btn0 = chg_b; else btn1 = chg_b;
            end
            o = (d == 0) ? {busy0, done0, latch0, pclk0, data0}
                         : {busy1, done1, latch1, pclk1, data1};
            if (o[4]) busy_last = c;
            if (o[3]) begin done_n++; done_c = c; end
            if (o[2]) begin lat_n++; if (lat_first < 0) lat_first = c; lat_last = c; end
            if (o[1] && !pc_prev) rises++;
            pc_prev = o[1];
            if (o[0]) begin if (dhi_first < 0) dhi_first = c; dhi_last = c; end
        end
    endtask

    initial begin
        int         dn;
        logic [4:0] lat_at;
        reset  = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        btn0   = '0;   btn1   = '0;

        // Reset held 5 cycles, then idle without start.
        repeat (5) @(negedge clk);
        check("reset_outs", int'({busy0, done0, latch0, pclk0, data0}), 0);
        check("reset_outs_f", int'({busy1, done1, latch1, pclk1, data1}), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_no_start", int'({busy0, done0, latch0, pclk0, data0}), 0);

        // START only.
        pulse_and_tally(0, 12'h100, 60, -1, 12'h000);
        check("t2_latch_first", lat_first, 1);
        check("t2_latch_last", lat_last, 4);
        check("t2_latch_n", lat_n, 4);
        check("t2_rises", rises, 12);
        check("t2_data_first", dhi_first, 17);
        check("t2_data_last", dhi_last, 20);
        check("t2_busy_last", busy_last, 52);
        check("t2_done_cycle", done_c, 53);
        check("t2_done_n", done_n, 1);
        check("t2_rx", int'(rx0), 12'h100);
        check("t2_rx_start", int'(rx0[BTN_START]), 1);

        // Buttons changing mid-frame must not leak into the frame.
        pulse_and_tally(0, 12'h000, 60, 10, 12'hFFF);
        check("t3_no_data", dhi_first, -1);
        check("t3_rx_zero", int'(rx0), 0);
        check("t3_done_cycle", done_c, 53);
        pulse_and_tally(0, 12'hFFF, 60, -1, 12'h000);
        check("t3_rx_ones", int'(rx0), 12'hFFF);
        check("t3_data_first", dhi_first, 5);
        check("t3_data_last", dhi_last, 52);
        check("t3_rx_dirs", int'({rx0[BTN_UP], rx0[BTN_DOWN], rx0[BTN_LEFT], rx0[BTN_RIGHT], rx0[BTN_START]}), 5'b11111);

        // Starts at 0, 20 (ignored) and 53 (done cycle, accepted).
        dn = 0; lat_n = 0; lat_at = '0;
        for (int c = 0; c <= 110; c++) begin
            if (done0) dn++;
            if (latch0) lat_n++;
            if (c == 53) lat_at[0] = latch0;
            if (c == 54) lat_at[1] = latch0;
            if (c == 57) lat_at[2] = latch0;
            if (c == 58) lat_at[3] = latch0;
            start0 = (c == 0 || c == 20 || c == 53);
            @(negedge clk);
        end
        start0 = 1'b0;
        check("t4_done_n", dn, 2);
        check("t4_latch_n", lat_n, 8);
        check("t4_latch_window", int'(lat_at[3:0]), 4'b0110);

        // Reset mid-frame at cycle 20.
        start0 = 1'b1; btn0 = 12'h5A3;
        dn = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (done0) dn++;
            if (c == 20) reset = 1'b1;
            if (c == 21) begin
                check("t5_after_reset", int'({busy0, done0, latch0, pclk0, data0}), 0);
                reset = 1'b0;
            end
        end
        check("t5_no_done", dn, 0);
        pulse_and_tally(0, 12'h5A3, 60, -1, 12'h000);
        check("t5_rx", int'(rx0), 12'h5A3);
        check("t5_done_cycle", done_c, 53);

        // Fast instance: LATCH_CYCLES=1, HALF_PERIOD=1.
        pulse_and_tally(1, 12'hA5A, 30, -1, 12'h000);
        check("t6_latch_first", lat_first, 1);
        check("t6_latch_n", lat_n, 1);
        check("t6_rises", rises, 12);
        check("t6_busy_last", busy_last, 25);
        check("t6_done_cycle", done_c, 26);
        check("t6_rx", int'(rx1), 12'hA5A);
        check("t6_rx_named", int'({rx1[BTN_B], rx1[BTN_SELECT], rx1[BTN_DOWN], rx1[BTN_RIGHT], rx1[BTN_A], rx1[BTN_L]}), 6'b111111);

        // Random starts, button churn and occasional resets on both instances.
        for (int c = 0; c < 4000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            start0 = ($urandom_range(0, 15) == 0);
            start1 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) btn0 = 12'($urandom);
            if ($urandom_range(0, 7) == 0) btn1 = 12'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (80) @(negedge clk);
        check("final_idle", int'({busy0, latch0, pclk0, busy1, latch1, pclk1}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
